// File: rtl/fpga_robots_game_config_pkg.sv
// Shared constants and types for the robots game tile map arbiter.
package fpga_robots_game_config_pkg;

    localparam int unsigned ADR_W      = 13;
    localparam int unsigned DAT_W      = 8;
    localparam int unsigned RDLAT_MIN  = 1;
    localparam int unsigned RDLAT_MAX  = 3;
    localparam int unsigned STARVE_MIN = 1;
    localparam int unsigned STARVE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // One slot of the read-tracking pipeline.
    typedef struct packed {
        logic   vld;
        owner_e owner;
    } track_t;

    // Access selected for the tile map port.
    typedef struct packed {
        logic             wen;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] wrt;
    } acc_t;

    function automatic int unsigned clamp_rdlat(input int unsigned r);
        if (r < RDLAT_MIN) return RDLAT_MIN;
        if (r > RDLAT_MAX) return RDLAT_MAX;
        return r;
    endfunction

    function automatic int unsigned clamp_starve(input int unsigned s);
        if (s < STARVE_MIN) return STARVE_MIN;
        if (s > STARVE_MAX) return STARVE_MAX;
        return s;
    endfunction

endpackage

// File: rtl/tmarb_rdtrack.sv
// Fixed-depth shift register that follows each granted access until its
// read data is due back from the tile map memory.
module tmarb_rdtrack
    import fpga_robots_game_config_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  track_t din,
    output track_t dout
);

    track_t stages [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/fpga_robots_game_tmarb.sv
// Two-requester arbiter for the tile map memory: game play (A) has priority,
// host debug (B) is protected from starvation; read data returned in order.
module fpga_robots_game_tmarb
    import fpga_robots_game_config_pkg::*;
#(
    parameter int unsigned RDLAT  = 1,
    parameter int unsigned STARVE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_wen,
    input  logic [ADR_W-1:0] a_adr,
    input  logic [DAT_W-1:0] a_wrt,
    output logic             a_gnt,
    output logic             a_vld,
    output logic [DAT_W-1:0] a_red,
    input  logic             b_req,
    input  logic             b_wen,
    input  logic [ADR_W-1:0] b_adr,
    input  logic [DAT_W-1:0] b_wrt,
    output logic             b_gnt,
    output logic             b_vld,
    output logic [DAT_W-1:0] b_red,
    output logic [ADR_W-1:0] tm_adr,
    output logic [DAT_W-1:0] tm_wrt,
    output logic             tm_wen,
    input  logic [DAT_W-1:0] tm_red
);

    localparam int unsigned      TRK_DEPTH  = clamp_rdlat(RDLAT) + 1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(clamp_starve(STARVE));

    logic             a_win_c;
    logic             b_win_c;
    logic             any_win_c;
    acc_t             sel_c;
    track_t           trk_in_c;
    track_t           trk_out;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt_c;
    logic             a_hit_c;
    logic             b_hit_c;

    logic [ADR_W-1:0] tm_adr_q;
    logic [DAT_W-1:0] tm_wrt_q;
    logic             tm_wen_q;
    logic [DAT_W-1:0] a_red_q;
    logic [DAT_W-1:0] b_red_q;

    // Arbitration, access select and starvation counter update.
    always_comb begin
        a_win_c          = 1'b0;
        b_win_c          = 1'b0;
        sel_c            = '0;
        trk_in_c         = '0;
        starve_cnt_nxt_c = starve_cnt;

        if (!rst) begin
            b_win_c = b_req && (!a_req || (starve_cnt == STARVE_LIM));
            a_win_c = a_req && !b_win_c;
        end
        any_win_c = a_win_c | b_win_c;

        sel_c.wen = b_win_c ? b_wen : a_wen;
        sel_c.adr = b_win_c ? b_adr : a_adr;
        sel_c.wrt = b_win_c ? b_wrt : a_wrt;

        trk_in_c.vld   = any_win_c && !sel_c.wen;
        trk_in_c.owner = b_win_c ? OWN_B : OWN_A;

        if (b_win_c || !b_req) begin
            starve_cnt_nxt_c = '0;
        end else if (a_win_c && (starve_cnt != STARVE_LIM)) begin
            starve_cnt_nxt_c = starve_cnt + CNT_W'(1);
        end
    end

    tmarb_rdtrack #(
        .DEPTH (TRK_DEPTH)
    ) u_rdtrack (
        .clk  (clk),
        .rst  (rst),
        .din  (trk_in_c),
        .dout (trk_out)
    );

    always_comb begin
        a_hit_c = !rst && trk_out.vld && (trk_out.owner == OWN_A);
        b_hit_c = !rst && trk_out.vld && (trk_out.owner == OWN_B);
    end

    // Memory port register; address and data hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            tm_adr_q   <= '0;
            tm_wrt_q   <= '0;
            tm_wen_q   <= 1'b0;
            a_red_q    <= '0;
            b_red_q    <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt_c;
            tm_wen_q   <= any_win_c && sel_c.wen;
            if (any_win_c) begin
                tm_adr_q <= sel_c.adr;
                tm_wrt_q <= sel_c.wrt;
            end
            if (a_hit_c) a_red_q <= tm_red;
            if (b_hit_c) b_red_q <= tm_red;
        end
    end

    // Read data tracks the memory during the valid cycle, then holds.
    always_comb begin
        a_gnt  = a_win_c;
        b_gnt  = b_win_c;
        a_vld  = a_hit_c;
        b_vld  = b_hit_c;
        a_red  = rst ? '0 : (a_hit_c ? tm_red : a_red_q);
        b_red  = rst ? '0 : (b_hit_c ? tm_red : b_red_q);
        tm_adr = rst ? '0 : tm_adr_q;
        tm_wrt = rst ? '0 : tm_wrt_q;
        tm_wen = !rst && tm_wen_q;
    end

endmodule

// File: tb/tb_fpga_robots_game_tmarb.sv
// Bench for the tile map arbiter: two instances (RDLAT=1 and RDLAT=2) share
// stimulus; read results are checked against a queue of expected returns.
module tb_fpga_robots_game_tmarb;

    logic clk = 1'b0;
    logic rst;
    logic a_req, a_wen, b_req, b_wen;
    logic [12:0] a_adr, b_adr;
    logic [7:0]  a_wrt, b_wrt;

    logic        a_gnt [2];
    logic        a_vld [2];
    logic [7:0]  a_red [2];
    logic        b_gnt [2];
    logic        b_vld [2];
    logic [7:0]  b_red [2];
    logic [12:0] tm_adr [2];
    logic [7:0]  tm_wrt [2];
    logic        tm_wen [2];
    logic [7:0]  tm_red [2];

    typedef struct {
        int         cyc;
        logic       own;
        logic [7:0] dat;
    } exp_t;

    exp_t       sbq [2][$];
    logic [7:0] ref_mem [8192];
    logic [7:0] mem [2][8192];
    logic [7:0] rp [2][3];
    logic [7:0] last_a [2];
    logic [7:0] last_b [2];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpga_robots_game_tmarb #(.RDLAT(1), .STARVE(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wen(a_wen), .a_adr(a_adr), .a_wrt(a_wrt),
        .a_gnt(a_gnt[0]), .a_vld(a_vld[0]), .a_red(a_red[0]),
        .b_req(b_req), .b_wen(b_wen), .b_adr(b_adr), .b_wrt(b_wrt),
        .b_gnt(b_gnt[0]), .b_vld(b_vld[0]), .b_red(b_red[0]),
        .tm_adr(tm_adr[0]), .tm_wrt(tm_wrt[0]), .tm_wen(tm_wen[0]), .tm_red(tm_red[0])
    );

    fpga_robots_game_tmarb #(.RDLAT(2), .STARVE(8)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wen(a_wen), .a_adr(a_adr), .a_wrt(a_wrt),
        .a_gnt(a_gnt[1]), .a_vld(a_vld[1]), .a_red(a_red[1]),
        .b_req(b_req), .b_wen(b_wen), .b_adr(b_adr), .b_wrt(b_wrt),
        .b_gnt(b_gnt[1]), .b_vld(b_vld[1]), .b_red(b_red[1]),
        .tm_adr(tm_adr[1]), .tm_wrt(tm_wrt[1]), .tm_wen(tm_wen[1]), .tm_red(tm_red[1])
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 'h0123) return 8'h5A;
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    function automatic int rl(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Tile map memory models with RDLAT-cycle read latency.
    assign tm_red[0] = rp[0][0];
    assign tm_red[1] = rp[1][1];

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[0][i] = init_val(i);
            mem[1][i] = init_val(i);
        end
        for (int d = 0; d < 2; d++) for (int k = 0; k < 3; k++) rp[d][k] = 8'h00;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                rp[d][0] <= mem[d][tm_adr[d]];
                rp[d][1] <= rp[d][0];
                rp[d][2] <= rp[d][1];
                if (tm_wen[d]) mem[d][tm_adr[d]] <= tm_wrt[d];
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_wen = 1'b0; a_adr = 13'h0; a_wrt = 8'h0;
        b_req = 1'b0; b_wen = 1'b0; b_adr = 13'h0; b_wrt = 8'h0;
    endtask

    task automatic push_rd(input logic own, input logic [12:0] adr);
        for (int d = 0; d < 2; d++) sbq[d].push_back('{cyc + 1 + rl(d), own, ref_mem[adr]});
    endtask

    // Compare read returns against the expected queue, check hold behaviour.
    task automatic scoreboard();
        exp_t e;
        logic [7:0] got;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (a_vld[d] && b_vld[d]) $display("FAIL dual_vld dut%0d cyc=%0d", d, cyc);
            else n_pass++;
            if (a_vld[d] || b_vld[d]) begin
                got = b_vld[d] ? b_red[d] : a_red[d];
                n_chk++;
                if (sbq[d].size() == 0) begin
                    $display("FAIL spurious_vld dut%0d cyc=%0d a_vld=%b b_vld=%b red=%h expected none",
                             d, cyc, a_vld[d], b_vld[d], got);
                end else begin
                    e = sbq[d].pop_front();
                    if (e.cyc != cyc || e.own !== b_vld[d] || got !== e.dat || got !== tm_red[d])
                        $display("FAIL read_return dut%0d cyc=%0d own=%b red=%h tm_red=%h expected cyc=%0d own=%b red=%h",
                                 d, cyc, b_vld[d], got, tm_red[d], e.cyc, e.own, e.dat);
                    else n_pass++;
                    if (b_vld[d]) last_b[d] = e.dat; else last_a[d] = e.dat;
                end
            end else if (sbq[d].size() > 0 && sbq[d][0].cyc <= cyc) begin
                e = sbq[d].pop_front();
                n_chk++;
                $display("FAIL missing_vld dut%0d cyc=%0d expected vld at cyc=%0d own=%b", d, cyc, e.cyc, e.own);
            end
            n_chk++;
            if ((!a_vld[d] && a_red[d] !== last_a[d]) || (!b_vld[d] && b_red[d] !== last_b[d]))
                $display("FAIL red_hold dut%0d cyc=%0d a_red=%h b_red=%h expected %h %h",
                         d, cyc, a_red[d], b_red[d], last_a[d], last_b[d]);
            else n_pass++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        scoreboard();
    endtask

    task automatic idle(input int n);
        idle_inputs();
        repeat (n) begin
            sample();
            adv();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        a_req = 1'b1; a_adr = 13'h0ABC; b_req = 1'b1; b_wen = 1'b1; b_wrt = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({a_gnt[d], b_gnt[d], a_vld[d], b_vld[d], tm_wen[d], tm_adr[d], tm_wrt[d], a_red[d], b_red[d]} !== '0)
                $display("FAIL reset_outputs dut%0d gnt=%b%b vld=%b%b wen=%b adr=%h wrt=%h red=%h/%h expected all zero",
                         d, a_gnt[d], b_gnt[d], a_vld[d], b_vld[d], tm_wen[d], tm_adr[d], tm_wrt[d], a_red[d], b_red[d]);
            else n_pass++;
            last_a[d] = 8'h00;
            last_b[d] = 8'h00;
        end
        adv();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_read();
        a_req = 1'b1; a_adr = 13'h0123;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (a_gnt[d] !== 1'b1 || b_gnt[d] !== 1'b0)
                $display("FAIL single_gnt dut%0d a_gnt=%b b_gnt=%b expected 1 0", d, a_gnt[d], b_gnt[d]);
            else n_pass++;
        end
        push_rd(1'b0, 13'h0123);
        adv();
        idle_inputs();
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (tm_adr[d] !== 13'h0123 || tm_wen[d] !== 1'b0)
                $display("FAIL single_tm dut%0d tm_adr=%h tm_wen=%b expected 0123 0", d, tm_adr[d], tm_wen[d]);
            else n_pass++;
        end
        adv();
        idle(5);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sbq[d].size() != 0) $display("FAIL single_drain dut%0d pending=%0d expected 0", d, sbq[d].size());
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int ia = 0;
        int ib = 0;
        logic exp_b;
        a_wen = 1'b0; b_wen = 1'b0;
        for (int i = 0; i < 42; i++) begin
            a_req = 1'b1;
            b_req = (i < 27) ? 1'b1 : (i != 32);
            a_adr = 13'(16'h0100 + ia);
            b_adr = 13'(16'h0200 + ib);
            exp_b = (i < 27) ? ((i % 9) == 8) : (i == 41);
            sample();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (a_gnt[d] !== !exp_b || b_gnt[d] !== exp_b)
                    $display("FAIL contention_gnt dut%0d step=%0d a_gnt=%b b_gnt=%b expected %b %b",
                             d, i, a_gnt[d], b_gnt[d], !exp_b, exp_b);
                else n_pass++;
            end
            if (exp_b) begin
                push_rd(1'b1, b_adr);
                ib++;
            end else begin
                push_rd(1'b0, a_adr);
                ia++;
            end
            adv();
        end
        idle(6);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sbq[d].size() != 0) $display("FAIL contention_drain dut%0d pending=%0d expected 0", d, sbq[d].size());
            else n_pass++;
        end
    endtask

    task automatic test_write();
        b_req = 1'b1; b_wen = 1'b1; b_adr = 13'h1FFF; b_wrt = 8'h3F;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (b_gnt[d] !== 1'b1 || a_gnt[d] !== 1'b0)
                $display("FAIL write_gnt dut%0d b_gnt=%b a_gnt=%b expected 1 0", d, b_gnt[d], a_gnt[d]);
            else n_pass++;
        end
        ref_mem[13'h1FFF] = 8'h3F;
        adv();
        idle_inputs();
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (tm_wen[d] !== 1'b1 || tm_adr[d] !== 13'h1FFF || tm_wrt[d] !== 8'h3F)
                $display("FAIL write_port dut%0d wen=%b adr=%h wrt=%h expected 1 1fff 3f", d, tm_wen[d], tm_adr[d], tm_wrt[d]);
            else n_pass++;
        end
        adv();
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (tm_wen[d] !== 1'b0 || tm_adr[d] !== 13'h1FFF || tm_wrt[d] !== 8'h3F)
                $display("FAIL write_idle dut%0d wen=%b adr=%h wrt=%h expected 0 1fff 3f", d, tm_wen[d], tm_adr[d], tm_wrt[d]);
            else n_pass++;
        end
        adv();
        a_req = 1'b1; a_adr = 13'h1FFF;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (a_gnt[d] !== 1'b1) $display("FAIL readback_gnt dut%0d a_gnt=%b expected 1", d, a_gnt[d]);
            else n_pass++;
        end
        push_rd(1'b0, 13'h1FFF);
        adv();
        idle(6);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sbq[d].size() != 0) $display("FAIL write_drain dut%0d pending=%0d expected 0", d, sbq[d].size());
            else n_pass++;
        end
    endtask

    task automatic test_interleave();
        logic        own [3] = '{1'b0, 1'b1, 1'b0};
        logic [12:0] adr [3] = '{13'h0001, 13'h0002, 13'h0003};
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (own[i]) begin b_req = 1'b1; b_adr = adr[i]; end
            else        begin a_req = 1'b1; a_adr = adr[i]; end
            sample();
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (a_gnt[d] !== !own[i] || b_gnt[d] !== own[i])
                    $display("FAIL interleave_gnt dut%0d step=%0d a_gnt=%b b_gnt=%b expected %b %b",
                             d, i, a_gnt[d], b_gnt[d], !own[i], own[i]);
                else n_pass++;
            end
            push_rd(own[i], adr[i]);
            adv();
        end
        idle(6);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sbq[d].size() != 0) $display("FAIL interleave_drain dut%0d pending=%0d expected 0", d, sbq[d].size());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        a_req = 1'b1; a_adr = 13'h0040;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (a_gnt[d] !== 1'b1) $display("FAIL midrst_gnt dut%0d a_gnt=%b expected 1", d, a_gnt[d]);
            else n_pass++;
        end
        adv();
        rst = 1'b1;
        a_adr = 13'h0055;
        for (int d = 0; d < 2; d++) begin
            sbq[d].delete();
            last_a[d] = 8'h00;
            last_b[d] = 8'h00;
        end
        sample();
        adv();
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({a_gnt[d], b_gnt[d], a_vld[d], b_vld[d], tm_wen[d], tm_adr[d], tm_wrt[d], a_red[d], b_red[d]} !== '0)
                $display("FAIL midrst_outputs dut%0d gnt=%b%b vld=%b%b wen=%b adr=%h wrt=%h red=%h/%h expected all zero",
                         d, a_gnt[d], b_gnt[d], a_vld[d], b_vld[d], tm_wen[d], tm_adr[d], tm_wrt[d], a_red[d], b_red[d]);
            else n_pass++;
        end
        adv();
        rst = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (a_gnt[d] !== 1'b1) $display("FAIL postrst_gnt dut%0d a_gnt=%b expected 1", d, a_gnt[d]);
            else n_pass++;
        end
        push_rd(1'b0, 13'h0055);
        adv();
        idle(6);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (sbq[d].size() != 0) $display("FAIL postrst_drain dut%0d pending=%0d expected 0", d, sbq[d].size());
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_interleave();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpga_robots_game_tmarb.md
FPGA_ROBOTS_GAME_TMARB -- requirements
Module: fpga_robots_game_tmarb

Interface
REQ-001 SHALL have parameter RDLAT, default 1: tile map memory read latency in cycles, from the cycle tm_adr is driven to the cycle tm_red is valid; legal range 1..3.
REQ-002 SHALL have parameter STARVE, default 8: maximum consecutive A grants while B waits; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single system clock (~65MHz); all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports a_req (in, 1), a_wen (in, 1), a_adr (in, 13), a_wrt (in, 8): requester A (game play) access request, write flag, address, write data.
REQ-006 SHALL have ports a_gnt (out, 1), a_vld (out, 1), a_red (out, 8): A grant, A read-data valid, A read data.
REQ-007 SHALL have ports b_req, b_wen, b_adr, b_wrt, b_gnt, b_vld, b_red: requester B (serial host debug access), widths and directions identical to A.
REQ-008 SHALL have ports tm_adr (out, 13), tm_wrt (out, 8), tm_wen (out, 1), tm_red (in, 8): tile map memory port.

Function
REQ-009 Requester SHALL hold req, wen, adr and wrt stable from req assertion until the cycle its gnt=1; gnt acknowledges exactly one access.
REQ-010 a_gnt/b_gnt SHALL be combinational from the current req inputs and registered arbiter state; at most one is 1 in any cycle.
REQ-011 Priority: A wins when both request, unless the starvation counter equals STARVE, in which case B wins.
REQ-012 Starvation counter (4 bits): increments on each A grant while b_req=1; clears on B grant or when b_req=0; never exceeds STARVE.
REQ-013 Granted access in cycle N SHALL appear on tm_adr/tm_wrt/tm_wen (registered) in cycle N+1; tm_wen=0 in every cycle following a cycle with no write grant.
REQ-014 tm_adr and tm_wrt SHALL retain their last values when idle; only tm_wen is forced to 0.
REQ-015 For a read granted in cycle N, the owner's vld SHALL be 1 for exactly one cycle, N+1+RDLAT, with red equal to tm_red in that cycle.
REQ-016 a_red/b_red SHALL be registered and hold their value between valid pulses; a write grant SHALL never produce vld.
REQ-017 Back-to-back grants SHALL be accepted every cycle; throughput is one access per cycle, with read results returned in grant order.
REQ-018 Tracking pipeline: RDLAT+1 stage shift register of {valid, owner}; one entry per cycle, no stalls.
REQ-019 Simultaneous events: a vld pulse for an earlier read and a new grant in the same cycle SHALL both take effect.

Reset
REQ-020 While rst=1: a_gnt=b_gnt=0, a_vld=b_vld=0, tm_wen=0, tm_adr=0, tm_wrt=0, a_red=b_red=0, starvation counter=0.
REQ-021 rst mid-operation SHALL flush the tracking pipeline; reads in flight produce no vld after reset; the first grant is possible in the first cycle with rst=0.

Structure
REQ-022 Address width 13, data width 8 and RDLAT range limits SHALL be constants in the shared fpga_robots_game_config definitions, not local literals.
REQ-023 The read-tracking shift register SHALL be one sub-module, tmarb_rdtrack, parameterized by depth; arbitration and starvation logic stay in the top module.

Verification
REQ-024 Single A read: A requests adr=0x0123 with mem[0x0123]=0x5A, granted in cycle 0 -> tm_adr=0x0123 in cycle 1; a_vld=1 and a_red=0x5A in cycle 2 (RDLAT=1); b_vld stays 0.
REQ-025 Contention: A and B both request continuously, STARVE=8 -> a_gnt for 8 cycles, then b_gnt for 1 cycle, then the pattern repeats.
REQ-026 Write: B writes 0x3F to 0x1FFF -> tm_wen=1, tm_adr=0x1FFF, tm_wrt=0x3F for exactly one cycle; no b_vld; a subsequent read of 0x1FFF returns 0x3F.
REQ-027 Interleaved reads: A read 0x0001, B read 0x0002, A read 0x0003 on consecutive cycles, with RDLAT=2 -> vld pulses in cycles 3, 4, 5 go to A, B, A respectively, each with the correct data.
REQ-028 Reset mid-read: A read granted in cycle 0, rst=1 in cycle 1 -> no a_vld in any later cycle; all outputs 0 while rst=1; a new A request is granted in the first cycle after reset releases.
